prio_grant_encoder: RTL and testbench

//  Parametrised, registered successor to the 8:3 priority encoder.

---
 rtl/prio_grant_encoder_pkg.sv | 20 ++
 rtl/prio_grant_encoder_pick.sv | 32 +++
 rtl/prio_grant_encoder.sv | 135 +++++++++++++
 tb/tb_prio_grant_encoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/prio_grant_encoder_pkg.sv
// Shared types and helpers for the registered priority/round-robin grant encoder.
package prio_pkg;

  // Two-state handshake FSM: nothing held, or a grant held until accepted.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } prio_state_t;

  // Ceiling log2 that never returns 0, so a width derived from it is always legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < n) begin
      r = r + 32'sd1;
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

endpackage

// File: rtl/prio_grant_encoder_pick.sv
// Combinational highest-set-bit picker: reports whether any bit is set, the
// index of the highest one, and that index as a one-hot vector.
module prio_pick
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Scan upward so the last (highest) set bit overwrites any lower winner.
  always_comb begin
    found = 1'b0;
    idx   = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      found = found | req[i];
      idx   = req[i] ? W'(i) : idx;
    end
    if (found) begin
      onehot = ONE << idx;
    end else begin
      onehot = {N{1'b0}};
    end
  end

endmodule

// File: rtl/prio_grant_encoder.sv
// Registered N-input priority encoder with run-time selectable fixed-priority
// or round-robin arbitration. A grant is held (sticky) on the outputs until the
// consumer accepts it; back-to-back accepts yield one grant per clock.
module prio_grant_encoder
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rr_mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         any_req
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  prio_state_t  state_r;
  logic [W-1:0] ptr_r;
  logic         accept_s;
  logic [W-1:0] ptr_eff_s;
  logic [N-1:0] mask_s;
  logic [N-1:0] masked_req_s;

  logic         found_f_s;
  logic [W-1:0] idx_f_s;
  logic [N-1:0] onehot_f_s;
  logic         found_m_s;
  logic [W-1:0] idx_m_s;
  logic [N-1:0] onehot_m_s;

  logic [W-1:0] win_idx_s;
  logic [N-1:0] win_onehot_s;

  assign any_req  = |req;
  assign accept_s = (state_r == HOLD) && out_ready;

  // On an accept the pointer moves to the accepted index in the same edge, so
  // the re-arbitration for the next grant must already see that new value.
  always_comb begin
    if (accept_s) begin
      ptr_eff_s = out_idx;
    end else begin
      ptr_eff_s = ptr_r;
    end
  end

  // Bits strictly below the pointer; empty when ptr is 0, forcing a full search.
  assign mask_s       = (ONE << ptr_eff_s) - ONE;
  assign masked_req_s = req & mask_s;

  prio_pick #(.N(N)) u_pick_full (
    .req    (req),
    .found  (found_f_s),
    .idx    (idx_f_s),
    .onehot (onehot_f_s)
  );

  prio_pick #(.N(N)) u_pick_masked (
    .req    (masked_req_s),
    .found  (found_m_s),
    .idx    (idx_m_s),
    .onehot (onehot_m_s)
  );

  // Round-robin prefers requests below the pointer, then wraps to the top;
  // fixed mode always takes the highest requester.
  always_comb begin
    if (rr_mode && found_m_s) begin
      win_idx_s    = idx_m_s;
      win_onehot_s = onehot_m_s;
    end else begin
      win_idx_s    = idx_f_s;
      win_onehot_s = onehot_f_s;
    end
  end

  // Handshake FSM owning the pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {W{1'b0}};
      out_valid  <= 1'b0;
      out_idx    <= {W{1'b0}};
      out_onehot <= {N{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (found_f_s) begin
            state_r    <= HOLD;
            out_valid  <= 1'b1;
            out_idx    <= win_idx_s;
            out_onehot <= win_onehot_s;
          end else begin
            state_r    <= IDLE;
            out_valid  <= 1'b0;
            out_idx    <= {W{1'b0}};
            out_onehot <= {N{1'b0}};
          end
        end
        HOLD: begin
          if (out_ready) begin
            ptr_r <= out_idx;
            if (found_f_s) begin
              state_r    <= HOLD;
              out_valid  <= 1'b1;
              out_idx    <= win_idx_s;
              out_onehot <= win_onehot_s;
            end else begin
              state_r    <= IDLE;
              out_valid  <= 1'b0;
              out_idx    <= {W{1'b0}};
              out_onehot <= {N{1'b0}};
            end
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r    <= IDLE;
          ptr_r      <= {W{1'b0}};
          out_valid  <= 1'b0;
          out_idx    <= {W{1'b0}};
          out_onehot <= {N{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_grant_encoder.sv
// Self-checking bench for prio_grant_encoder (N=8): directed scenarios with
// explicit expected values, then randomized traffic against a reference model.
module tb_prio_grant_encoder;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         rr_mode;
  logic         out_ready;
  logic         out_valid;
  logic [2:0]   out_idx;
  logic [N-1:0] out_onehot;
  logic         any_req;

  int n_checks;
  int n_fail;

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;

  prio_grant_encoder #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rr_mode    (rr_mode),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .any_req    (any_req)
  );

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner by the stated rules: fixed = highest index; round-robin = first set
  // bit searching downward from ptr-1 with wrap, ptr itself checked last.
  function automatic int arbitrate(input logic [N-1:0] r, input bit rr, input int p);
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (p - k + N) % N;
        if (r[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic model_update(input logic [N-1:0] r, input bit rr, input bit rdy, input bit rs);
    if (rs) begin
      m_valid = 1'b0; m_idx = 0; m_ptr = 0;
    end else if (!m_valid) begin
      if (r != '0) begin
        m_idx = arbitrate(r, rr, m_ptr); m_valid = 1'b1;
      end
    end else if (rdy) begin
      m_ptr = m_idx;
      if (r != '0) m_idx = arbitrate(r, rr, m_ptr);
      else begin m_valid = 1'b0; m_idx = 0; end
    end
  endtask

  // One clock: drive inputs, check any_req, clock, compare against the model.
  task automatic step(input logic [N-1:0] r, input logic rr, input logic rdy, input logic rs);
    logic [N-1:0] exp_oh;
    req = r; rr_mode = rr; out_ready = rdy; rst = rs;
    #1;
    check_val("any_req", {31'd0, any_req}, {31'd0, |r});
    @(posedge clk);
    model_update(r, rr, rdy, rs);
    #1;
    exp_oh = m_valid ? (8'h01 << m_idx) : 8'h00;
    check_val("model_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_val("model_idx", {29'd0, out_idx}, m_idx);
    check_val("model_onehot", {24'd0, out_onehot}, {24'd0, exp_oh});
  endtask

  task automatic expect_out(input string tag, input logic v, input int idx, input logic [N-1:0] oh);
    check_val({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check_val({tag, "_idx"}, {29'd0, out_idx}, idx);
    check_val({tag, "_onehot"}, {24'd0, out_onehot}, {24'd0, oh});
  endtask

  initial begin
    int rr_seq[9];
    n_checks = 0; n_fail = 0;
    m_valid = 1'b0; m_idx = 0; m_ptr = 0;
    req = '0; rr_mode = 1'b0; out_ready = 1'b0; rst = 1'b1;
    rr_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    // 1. Reset with all requests asserted
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    expect_out("reset", 1'b0, 0, 8'h00);

    // 2. Fixed priority, sticky hold while not ready
    step(8'b0010_1100, 1'b0, 1'b0, 1'b0);
    expect_out("fixed", 1'b1, 5, 8'h20);
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b1, 1'b0, 1'b0);
      expect_out("hold", 1'b1, 5, 8'h20);
    end

    // 3. Round-robin rotation from a fresh reset
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, 1'b1, 1'b0);
      expect_out("rr_seq", 1'b1, rr_seq[i], 8'h01 << rr_seq[i]);
    end

    // 4. Wrap: get idx 0 granted, then accept it with 8'b1000_0001
    step(8'h01, 1'b1, 1'b1, 1'b0);
    expect_out("wrap_pre", 1'b1, 0, 8'h01);
    step(8'b1000_0001, 1'b1, 1'b1, 1'b0);
    expect_out("wrap_7", 1'b1, 7, 8'h80);
    step(8'b1000_0001, 1'b1, 1'b1, 1'b0);
    expect_out("wrap_0", 1'b1, 0, 8'h01);

    // 5. Reset mid-grant
    step(8'h08, 1'b1, 1'b1, 1'b0);
    expect_out("mid_pre", 1'b1, 3, 8'h08);
    step(8'h08, 1'b1, 1'b0, 1'b1);
    expect_out("mid_rst", 1'b0, 0, 8'h00);
    step(8'h08, 1'b1, 1'b0, 1'b0);
    expect_out("mid_post", 1'b1, 3, 8'h08);

    // 6. Accept with no requests, ready ignored in IDLE, then a new request
    step(8'h00, 1'b1, 1'b1, 1'b0);
    expect_out("empty", 1'b0, 0, 8'h00);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    expect_out("idle_rdy", 1'b0, 0, 8'h00);
    step(8'h02, 1'b1, 1'b0, 1'b0);
    expect_out("late_req", 1'b1, 1, 8'h02);

    // Randomized traffic checked against the model
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      else if ($urandom_range(0, 3) == 0) r = 8'h01 << $urandom_range(0, 7);
      step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
